alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Round-robin arbiter and sequencer that shares one fixed-point ALU (Q6.10, 4-bit opcode, 2-cycle in-valid→out-valid) between two requesters. It accepts one request at a time over a valid/ready handshake and rejects illegal opcodes locally. It issues legal requests to the ALU only when the ALU reports not busy, captures the result, and returns it to the owning requester with backpressure. A watchdog converts a missing ALU response into an error completion.

## Interface
- INST_W, 4, opcode width
- DATA_W, 16, data width (Q6.10)
- TIMEOUT, 15, max cycles in WAIT before error completion (≥3)
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req_valid  in  2  per-requester request valid
- o_req_ready  out  2  per-requester accept, one-hot or zero
- i_req_inst  in  2*INST_W  opcodes; requester k at bits [k*INST_W +: INST_W]
- i_req_data_a / i_req_data_b  in  2*DATA_W each  operands, same packing
- o_rsp_valid  out  2  one-hot response valid
- i_rsp_ready  in  2  per-requester response accept
- o_rsp_data  out  DATA_W  result, shared by both requesters
- o_rsp_err  out  1  response is an error (illegal opcode or timeout)
- o_alu_valid  out  1  issue pulse to ALU i_in_valid
- i_alu_busy  in  1  ALU o_busy
- o_alu_inst  out  INST_W  opcode to ALU
- o_alu_data_a / o_alu_data_b  out  DATA_W  operands to ALU
- i_alu_out_valid  in  1  ALU o_out_valid
- i_alu_data  in  DATA_W  ALU o_data
- o_err_cnt  out  8  saturating count of error completions

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset → IDLE.
- Reset values: all outputs 0, rr pointer 0 (requester 0 favoured), latched request 0, err counter 0.
- IDLE:
  - o_req_ready is combinational: the winner bit is set only in IDLE when at least one i_req_valid is high.
  - Winner is the requester at the rr pointer if it is valid, else the other one.
  - On handshake, latch inst/a/b and the requester id.
  - Opcode > 9: next state RESP with err=1 and data 0. Otherwise next state ISSUE.
- ISSUE:
  - o_alu_valid = !i_alu_busy. o_alu_inst/data are driven from the latch in all states.
  - When o_alu_valid is high, go to WAIT and clear the timeout counter. Otherwise stay in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - i_alu_out_valid: capture i_alu_data, err=0, go to RESP.
  - Else if counter == TIMEOUT: data 0, err=1, go to RESP.
  - If both happen in the same cycle, the result wins.
- RESP:
  - o_rsp_valid[id] = 1; o_rsp_data and o_rsp_err are held stable.
  - On i_rsp_ready[id], go to IDLE and set the rr pointer to the other requester.
  - i_rsp_ready of the non-owner is ignored.
- o_err_cnt increments on each error response handshake and saturates at 255.
- Exactly one ALU operation is outstanding at a time. Commands (including ACC to one bank) execute in grant order.
- Requests are not buffered: a valid request that is not granted holds until its ready.
- Reset mid-operation: return to IDLE immediately and drop the in-flight request. The ALU shares i_rst_n, so no stale o_out_valid follows.

## Timing
- Accept in cycle T → o_alu_valid in T+1 (ALU idle) → ALU out_valid in T+3 → o_rsp_valid from T+4.
- If the ALU is busy in T+1, every later step slips one cycle per busy cycle.
- Illegal opcode: o_rsp_valid from T+1.
- Timeout: o_rsp_valid one cycle after the cycle in which counter == TIMEOUT.
- Response accepted in cycle R → IDLE in R+1; the next accept is possible in R+1.
- Back-to-back throughput with an always-ready sink: one op per 5 cycles.
- o_alu_valid is never high while i_alu_busy is high, and never high for two consecutive cycles.

## Test plan
- Reset: assert i_rst_n=0 mid-WAIT → all outputs 0, state IDLE. After release, req0 ADD a=0x0400 b=0x0800 → rsp_valid=01 at T+4, data 0x0C00, err 0.
- Fairness: both requesters held valid continuously (req0 XOR 0x00FF^0x0F0F, req1 SUB 0x0400-0x0C00) → grants alternate 0,1,0,1; responses 0x0FF0 and 0xF800 to the matching one-hot valid.
- Illegal opcode: req1 inst=0xC → ALU never pulsed; rsp_valid=10 at T+1, data 0, err 1, o_err_cnt=1.
- Backpressure: hold i_rsp_ready=0 for 6 cycles → rsp data stable, no new o_req_ready despite pending req0. On ready → next grant in the following cycle.
- Busy/timeout: hold i_alu_busy=1 for 3 cycles → o_alu_valid delayed exactly 3 cycles. Never assert out_valid → err response after TIMEOUT; out_valid coincident with counter==TIMEOUT → normal result, err 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared fixed-point ALU.
// Holds one request at a time, filters illegal opcodes, and guards the ALU response with a watchdog.
module alu_req_arbiter #(
  parameter int INST_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [2*INST_W-1:0] i_req_inst,
  input  logic [2*DATA_W-1:0] i_req_data_a,
  input  logic [2*DATA_W-1:0] i_req_data_b,
  output logic [1:0]          o_rsp_valid,
  input  logic [1:0]          i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_err,
  output logic                o_alu_valid,
  input  logic                i_alu_busy,
  output logic [INST_W-1:0]   o_alu_inst,
  output logic [DATA_W-1:0]   o_alu_data_a,
  output logic [DATA_W-1:0]   o_alu_data_b,
  input  logic                i_alu_out_valid,
  input  logic [DATA_W-1:0]   i_alu_data,
  output logic [7:0]          o_err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [INST_W-1:0] MAX_OP = INST_W'(9);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state, state_nxt;
  logic                      rr;
  logic                      owner;
  logic [INST_W-1:0]         inst_q;
  logic signed [DATA_W-1:0]  a_q, b_q;
  logic signed [DATA_W-1:0]  rsp_data_q;
  logic                      rsp_err_q;
  logic [CNT_W-1:0]          cnt;
  logic [7:0]                err_cnt_q;

  logic                      win;
  logic [INST_W-1:0]         win_inst;
  logic signed [DATA_W-1:0]  win_a, win_b;
  logic                      win_illegal;
  logic                      accept;
  logic                      rsp_hs;
  logic                      timeout_hit;

  // Winner selection: the favoured requester if it asks, otherwise the other one.
  always_comb begin
    win         = i_req_valid[rr] ? rr : ~rr;
    win_inst    = win ? i_req_inst[2*INST_W-1:INST_W] : i_req_inst[INST_W-1:0];
    win_a       = win ? i_req_data_a[2*DATA_W-1:DATA_W] : i_req_data_a[DATA_W-1:0];
    win_b       = win ? i_req_data_b[2*DATA_W-1:DATA_W] : i_req_data_b[DATA_W-1:0];
    win_illegal = (win_inst > MAX_OP);
    timeout_hit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 2'b00;
    o_alu_valid = 1'b0;
    o_rsp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (|i_req_valid) begin
          o_req_ready = win ? 2'b10 : 2'b01;
          state_nxt   = win_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        o_alu_valid = !i_alu_busy;
        if (!i_alu_busy) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_alu_out_valid || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid = owner ? 2'b10 : 2'b01;
        if (i_rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = |o_req_ready;
  assign rsp_hs = (state == RESP) && i_rsp_ready[owner];

  // Request latch, result capture, watchdog and error statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr         <= 1'b0;
      owner      <= 1'b0;
      inst_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt        <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (accept) begin
        owner  <= win;
        inst_q <= win_inst;
        a_q    <= win_a;
        b_q    <= win_b;
        if (win_illegal) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (o_alu_valid) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
        // A result arriving on the deadline cycle still counts as a result.
        if (i_alu_out_valid) begin
          rsp_data_q <= i_alu_data;
          rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (rsp_hs) begin
        rr <= ~owner;
        if (rsp_err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign o_alu_inst   = inst_q;
  assign o_alu_data_a = a_q;
  assign o_alu_data_b = b_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a 2-cycle behavioural ALU.
// Grants and responses are checked by a negedge monitor; directed phases check timing.
module tb_alu_req_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  inst_r [2];
  logic [15:0] a_r [2];
  logic [15:0] b_r [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_valid;
  logic        alu_busy = 1'b0;
  logic [3:0]  alu_inst;
  logic [15:0] alu_a, alu_b;
  logic        alu_out_valid;
  logic [15:0] alu_data;
  logic [7:0]  err_cnt;

  logic        drop = 1'b0;
  logic        force_ov = 1'b0;
  logic [15:0] force_data = 16'h0;
  int          mode = 0;

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [17:0] sb [$];
  int          glog [$];
  int          gcyc [$];
  logic [15:0] last_rsp [2];

  alu_req_arbiter #(.INST_W(4), .DATA_W(16), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_inst({inst_r[1], inst_r[0]}),
    .i_req_data_a({a_r[1], a_r[0]}), .i_req_data_b({b_r[1], b_r[0]}),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_alu_valid(alu_valid), .i_alu_busy(alu_busy),
    .o_alu_inst(alu_inst), .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
    .i_alu_out_valid(alu_out_valid), .i_alu_data(alu_data),
    .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // Behavioural ALU: result two cycles after the issue pulse.
  logic        p1, p2;
  logic [15:0] r1, r2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0; p2 <= 1'b0; r1 <= '0; r2 <= '0;
    end else begin
      p1 <= alu_valid;
      if (alu_valid) r1 <= alu_fn(alu_inst, alu_a, alu_b);
      p2 <= p1;
      r2 <= r1;
    end
  end
  assign alu_out_valid = (p2 && !drop) || force_ov;
  assign alu_data      = force_ov ? force_data : r2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int t);
    int n = 0;
    inst_r[id] = op; a_r[id] = a; b_r[id] = b;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 100) begin tick(); n++; end
    chk("accept_seen", req_ready[id], 1);
    t = cyc;
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, output int t);
    int n = 0;
    while (!rsp_valid[id] && n < 100) begin tick(); n++; end
    chk("rsp_seen", rsp_valid[id], 1);
    t = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain", sb.size(), 0);
    tick();
  endtask

  // Monitor: grant order model, invariants and response scoreboard.
  initial begin
    int exp_rr = 0;
    logic prev_av = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_rr = 0;
        prev_av = 1'b0;
      end else begin
        chk("ready_onehot", $onehot0(req_ready), 1);
        chk("rsp_onehot", $onehot0(rsp_valid), 1);
        chk("issue_while_busy", alu_valid & alu_busy, 0);
        chk("issue_back2back", alu_valid & prev_av, 0);
        prev_av = alu_valid;
        if (|(req_valid & req_ready)) begin
          int gid;
          logic [17:0] e;
          gid = req_ready[1] ? 1 : 0;
          chk("grant", gid, req_valid[exp_rr] ? exp_rr : 1 - exp_rr);
          glog.push_back(gid);
          gcyc.push_back(cyc);
          if (mode == 1)                  e = {gid[0], 1'b1, 16'h0000};
          else if (mode == 2)             e = {gid[0], 1'b0, force_data};
          else if (inst_r[gid] > 4'd9)    e = {gid[0], 1'b1, 16'h0000};
          else                            e = {gid[0], 1'b0, alu_fn(inst_r[gid], a_r[gid], b_r[gid])};
          sb.push_back(e);
        end
        if (|(rsp_valid & rsp_ready)) begin
          int oid;
          oid = rsp_valid[1] ? 1 : 0;
          chk("sb_pending", sb.size() > 0, 1);
          if (sb.size() > 0) chk("rsp", {oid[0], rsp_err, rsp_data}, sb.pop_front());
          last_rsp[oid] = rsp_data;
          exp_rr = 1 - oid;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int t, tr, ti, base;
    for (int k = 0; k < 2; k++) begin inst_r[k] = '0; a_r[k] = '0; b_r[k] = '0; end

    // Reset values
    repeat (3) tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    tick();

    // Reset while waiting on the ALU
    drop = 1'b1; mode = 1;
    send(0, 4'd3, 16'h0400, 16'h0800, t);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu_valid", alu_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_err", rsp_err, 0);
    chk("midrst_alu_inst", alu_inst, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    drop = 1'b0; mode = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic ADD latency
    send(0, OP_ADD, 16'h0400, 16'h0800, t);
    #1 chk("add_issue_t1", alu_valid, 1);
    wait_rsp(0, tr);
    chk("add_rsp_t4", tr, t + 4);
    chk("add_rsp_valid", rsp_valid, 2'b01);
    chk("add_data", rsp_data, 16'h0C00);
    chk("add_err", rsp_err, 0);
    drain();

    // Illegal opcode
    send(1, 4'hC, 16'h1111, 16'h2222, t);
    #1 chk("ill_no_issue", alu_valid, 0);
    wait_rsp(1, tr);
    chk("ill_rsp_t1", tr, t + 1);
    chk("ill_rsp_valid", rsp_valid, 2'b10);
    chk("ill_data", rsp_data, 0);
    chk("ill_err", rsp_err, 1);
    tick();
    chk("ill_err_cnt", err_cnt, 1);
    drain();

    // Fairness with both requesters permanently valid
    inst_r[0] = OP_XOR; a_r[0] = 16'h00FF; b_r[0] = 16'h0F0F;
    inst_r[1] = OP_SUB; a_r[1] = 16'h0400; b_r[1] = 16'h0C00;
    base = glog.size();
    req_valid = 2'b11;
    for (int n = 0; n < 60 && glog.size() < base + 4; n++) tick();
    req_valid = 2'b00;
    chk("fair_grants", glog.size(), base + 4);
    if (glog.size() >= base + 4) begin
      chk("fair_g0", glog[base], 0);
      chk("fair_g1", glog[base + 1], 1);
      chk("fair_g2", glog[base + 2], 0);
      chk("fair_g3", glog[base + 3], 1);
      chk("fair_period", gcyc[base + 1] - gcyc[base], 5);
    end
    drain();
    chk("fair_data0", last_rsp[0], 16'h0FF0);
    chk("fair_data1", last_rsp[1], 16'hF800);

    // Backpressure on the response side
    rsp_ready = 2'b00;
    send(1, OP_ADD, 16'h1000, 16'h0234, t);
    inst_r[0] = OP_XOR; a_r[0] = 16'h00FF; b_r[0] = 16'h0F0F;
    req_valid[0] = 1'b1;
    wait_rsp(1, tr);
    chk("bp_data", rsp_data, 16'h1234);
    for (int k = 0; k < 6; k++) begin
      rsp_ready = 2'b01;
      #1;
      chk("bp_valid_held", rsp_valid, 2'b10);
      chk("bp_data_held", rsp_data, 16'h1234);
      chk("bp_no_grant", req_ready, 0);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    chk("bp_next_grant", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    rsp_ready = 2'b11;
    drain();

    // ALU busy delays issue
    alu_busy = 1'b1;
    send(0, OP_ADD, 16'h0100, 16'h0200, t);
    for (int k = 0; k < 3; k++) begin
      #1 chk("busy_hold", alu_valid, 0);
      tick();
    end
    alu_busy = 1'b0;
    #1;
    chk("busy_release", alu_valid, 1);
    chk("busy_issue_t4", cyc, t + 4);
    wait_rsp(0, tr);
    chk("busy_rsp_t7", tr, t + 7);
    drain();

    // Watchdog timeout
    drop = 1'b1; mode = 1;
    send(0, OP_ADD, 16'h0001, 16'h0002, t);
    ti = cyc;
    #1 chk("to_issue", alu_valid, 1);
    wait_rsp(0, tr);
    chk("to_rsp_time", tr, ti + 17);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    tick();
    chk("to_err_cnt", err_cnt, 2);
    drop = 1'b0; mode = 0;
    drain();

    // Result coincident with the deadline
    drop = 1'b1; mode = 2; force_data = 16'h2BCD;
    send(1, OP_ADD, 16'h0001, 16'h0002, t);
    ti = cyc;
    repeat (16) tick();
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    chk("co_rsp_valid", rsp_valid, 2'b10);
    chk("co_err", rsp_err, 0);
    chk("co_data", rsp_data, 16'h2BCD);
    tick();
    chk("co_err_cnt", err_cnt, 2);
    drop = 1'b0; mode = 0;
    drain();

    // Error counter saturation
    for (int k = 0; k < 253; k++) send(0, 4'hF, 16'h0, 16'h0, t);
    tick();
    chk("sat_255", err_cnt, 255);
    send(1, 4'hA, 16'h0, 16'h0, t);
    tick();
    chk("sat_hold", err_cnt, 255);
    drain();

    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
